// File: rtl/riscv_mem_pkg.sv
// Shared memory-side types: arbiter FSM state and access owner encodings.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DMA  = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between core and DMA requesters.
// `DMEM_ARB_RR_EN selects round-robin; otherwise the core has fixed priority.
module dmem_arb_pick
  import riscv_mem_pkg::*;
(
  input  logic   core_elig,
  input  logic   dma_elig,
  input  owner_e last_owner,
  output logic   grant,
  output owner_e winner
);

  always_comb begin
    grant  = core_elig | dma_elig;
    winner = OWN_CORE;
    if (!core_elig)
      winner = OWN_DMA;
`ifdef DMEM_ARB_RR_EN
    // On a tie, whoever did not own the previous access goes next.
    else if (dma_elig && (last_owner == OWN_CORE))
      winner = OWN_DMA;
`endif
  end

`ifndef DMEM_ARB_RR_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises core and DMA accesses onto the single-port DMEM (IDLE->ACCESS->WAIT).
// Arbitration policy set by `DMEM_ARB_RR_EN inside dmem_arb_pick.
module dmem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  output logic              core_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              core_ack_q, core_ack_d;
  logic              dma_ack_q, dma_ack_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic   core_elig, dma_elig, grant;
  owner_e winner;

  // A port is not eligible in its own ack cycle, so a held req is not re-served.
  assign core_elig = core_req & ~core_ack_q;
  assign dma_elig  = dma_req  & ~dma_ack_q;

  dmem_arb_pick u_pick (
    .core_elig  (core_elig),
    .dma_elig   (dma_elig),
    .last_owner (last_owner_q),
    .grant      (grant),
    .winner     (winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ACCESS;
      ACCESS:  state_d = WAIT;
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = (state_q == ACCESS);
    mem_we    = mem_en & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
  end

  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    core_ack_d   = 1'b0;
    dma_ack_d    = 1'b0;
    core_rdata_d = core_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    if ((state_q == IDLE) && grant) begin
      owner_d      = winner;
      last_owner_d = winner;
      if (winner == OWN_CORE) begin
        we_d    = core_we;
        addr_d  = core_addr[MEM_AW+1:2];
        wdata_d = core_wdata;
      end else begin
        we_d    = dma_we;
        addr_d  = dma_addr[MEM_AW+1:2];
        wdata_d = dma_wdata;
      end
    end
    // mem_rdata is valid in WAIT, one cycle after the ACCESS strobe.
    if (state_q == WAIT) begin
      if (owner_q == OWN_CORE) begin
        core_ack_d = 1'b1;
        if (!we_q) core_rdata_d = mem_rdata;
      end else begin
        dma_ack_d = 1'b1;
        if (!we_q) dma_rdata_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q      <= OWN_CORE;
      last_owner_q <= OWN_DMA;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_ack_q   <= 1'b0;
      dma_ack_q    <= 1'b0;
      core_rdata_q <= '0;
      dma_rdata_q  <= '0;
    end else begin
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_ack_q   <= core_ack_d;
      dma_ack_q    <= dma_ack_d;
      core_rdata_q <= core_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign core_ack   = core_ack_q;
  assign dma_ack    = dma_ack_q;
  assign core_rdata = core_rdata_q;
  assign dma_rdata  = dma_rdata_q;
  assign core_stall = core_req & ~core_ack_q;

  // Byte-offset and above-depth address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{core_addr, dma_addr};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, corner sequences, random traffic vs reference.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        core_req = 0, core_we = 0, dma_req = 0, dma_we = 0;
  logic [31:0] core_addr = 0, core_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic [31:0] core_rdata, dma_rdata, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic        core_ack, core_stall, dma_ack, mem_en, mem_we;
  logic [7:0]  mem_addr;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_AW(8)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_ack(core_ack), .core_stall(core_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port DMEM with one-cycle read latency.
  logic [31:0] dmem [256];
  logic        clr_mem = 1'b1;
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) dmem[mem_addr] <= mem_wdata;
      mem_rdata <= dmem[mem_addr];
    end
  end

  int en_cnt = 0;
  always @(negedge clk) if (mem_en) en_cnt <= en_cnt + 1;

  int nchk = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input bit port, input bit req, input bit we, input logic [31:0] a, input logic [31:0] wd);
    if (port) begin dma_req = req; dma_we = we; dma_addr = a; dma_wdata = wd; end
    else begin core_req = req; core_we = we; core_addr = a; core_wdata = wd; end
  endtask

  task automatic do_reset();
    core_req = 0; dma_req = 0;
    rst = 0;
    repeat (2) tick();
    rst = 1;
    tick();
  endtask

  // One isolated transaction: req in cycle 0, strobe in 1, ack in 3, req dropped in 4.
  task automatic txn(input bit port, input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [7:0] ema, input logic [31:0] erd);
    drive(port, 1, we, a, wd);
    smp();
    chk("c0_en", mem_en, 0);
    chk("c0_stall", core_stall, port == 0);
    tick(); smp();
    chk("acc_en", mem_en, 1);
    chk("acc_we", mem_we, we);
    chk("acc_addr", mem_addr, ema);
    if (we) chk("acc_wdata", mem_wdata, wd);
    chk("acc_stall", core_stall, port == 0);
    tick(); smp();
    chk("wait_en", mem_en, 0);
    chk("wait_acks", {core_ack, dma_ack}, 0);
    chk("wait_stall", core_stall, port == 0);
    tick(); smp();
    chk("ack_own", port ? dma_ack : core_ack, 1);
    chk("ack_other", port ? core_ack : dma_ack, 0);
    chk("ack_stall", core_stall, 0);
    if (!we) chk("ack_rdata", port ? dma_rdata : core_rdata, erd);
    tick();
    drive(port, 0, we, a, wd);
  endtask

  // Both ports request in cycle 0; acks compared against per-cycle masks.
  task automatic run_pair(input string nm, input bit hold, input int drop_c, input int ncyc,
                          input logic [31:0] cmask, input logic [31:0] dmask);
    bit cd = 0, dd = 0;
    drive(0, 1, 0, 32'h200, 0);
    drive(1, 1, 0, 32'h204, 0);
    for (int c = 0; c < ncyc; c++) begin
      if (hold) begin
        if (c == drop_c) begin core_req = 0; dma_req = 0; end
      end else begin
        if (cd) core_req = 0;
        if (dd) dma_req = 0;
      end
      smp();
      chk({nm, "_core_ack"}, core_ack, cmask[c]);
      chk({nm, "_dma_ack"}, dma_ack, dmask[c]);
      if (core_ack) cd = 1;
      if (dma_ack) dd = 1;
      tick();
    end
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  ma;
    logic [31:0] rd;
  } vec_t;

  vec_t vt[8];

  // Reference model state for the random phase.
  logic [31:0] ref_mem [256];
  bit          pend[2], rq_we[2], ea[2], el[2];
  logic [31:0] rq_addr[2], rq_wd[2], exp_rd[2];
  int          due[2];
  int          free_c, gcyc, w, e0;
  bit          last;
  logic [7:0]  exp_ma;
  bit          exp_we;
  logic [31:0] exp_wd;

  initial begin
    vt[0] = '{0, 1, 32'h100, 32'd15,        8'h40, 32'h0};
    vt[1] = '{0, 0, 32'h100, 32'h0,         8'h40, 32'd15};
    vt[2] = '{1, 1, 32'h400, 32'hA5A5_0001, 8'h00, 32'h0};
    vt[3] = '{0, 0, 32'h000, 32'h0,         8'h00, 32'hA5A5_0001};
    vt[4] = '{0, 1, 32'h3FC, 32'hDEAD_BEEF, 8'hFF, 32'h0};
    vt[5] = '{1, 0, 32'h7FC, 32'h0,         8'hFF, 32'hDEAD_BEEF};
    vt[6] = '{0, 1, 32'h103, 32'h77,        8'h40, 32'h0};
    vt[7] = '{1, 0, 32'h100, 32'h0,         8'h40, 32'h77};

    repeat (2) tick();
    smp();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_core_ack", core_ack, 0);
    chk("rst_dma_ack", dma_ack, 0);
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_dma_rdata", dma_rdata, 0);
    chk("rst_stall", core_stall, 0);
    clr_mem = 0;
    rst = 1;
    tick();

    for (int i = 0; i < 8; i++) begin
      txn(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].ma, vt[i].rd);
      if (i == 0) chk("dmem_word64", dmem[64], 15);
    end

    // Req held through its ack cycle must produce exactly one access.
    e0 = en_cnt;
    txn(0, 0, 32'h100, 0, 8'h40, 32'h77);
    repeat (2) tick();
    chk("single_pulse", en_cnt - e0, 1);

    // Both held: the acked port sits out its ack cycle, so the other takes each slot.
    do_reset();
    run_pair("hold", 1, 13, 17, (32'd1 << 3) | (32'd1 << 9) | (32'd1 << 15),
             (32'd1 << 6) | (32'd1 << 12));

    // Last owner is now core; a fresh tie shows the policy.
`ifdef DMEM_ARB_RR_EN
    run_pair("tie", 0, 0, 8, 32'd1 << 6, 32'd1 << 3);
`else
    run_pair("tie", 0, 0, 8, 32'd1 << 3, 32'd1 << 6);
`endif

    // Reset in ACCESS of a DMA read, then reissue.
    drive(1, 1, 0, 32'h100, 0);
    smp();
    tick(); smp();
    chk("rst_mid_pre_en", mem_en, 1);
    #2 rst = 0;
    #1;
    chk("rst_mid_en", mem_en, 0);
    chk("rst_mid_ack", dma_ack, 0);
    tick();
    chk("rst_mid_en2", mem_en, 0);
    chk("rst_mid_ack2", {core_ack, dma_ack}, 0);
    rst = 1;
    txn(1, 0, 32'h100, 0, 8'h40, 32'h77);

    // Random traffic against a transaction-level model.
    rst = 0; clr_mem = 1;
    repeat (2) tick();
    clr_mem = 0; rst = 1;
    tick();
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    pend = '{0, 0}; due = '{-1, -1};
    free_c = 0; gcyc = -10; last = 1;
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 2) == 0)) begin
          pend[p]    = 1;
          rq_we[p]   = 1'($urandom_range(0, 1));
          rq_addr[p] = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2)
                       | 32'($urandom_range(0, 3));
          rq_wd[p]   = $urandom;
        end
        drive(p[0], pend[p], rq_we[p], rq_addr[p], rq_wd[p]);
      end
      smp();
      for (int p = 0; p < 2; p++) ea[p] = (due[p] == c);
      chk("rnd_core_ack", core_ack, ea[0]);
      chk("rnd_dma_ack", dma_ack, ea[1]);
      chk("rnd_stall", core_stall, pend[0] && !ea[0]);
      chk("rnd_mem_en", mem_en, c == gcyc + 1);
      if (c == gcyc + 1) begin
        chk("rnd_mem_addr", mem_addr, exp_ma);
        chk("rnd_mem_we", mem_we, exp_we);
        if (exp_we) chk("rnd_mem_wdata", mem_wdata, exp_wd);
      end
      if (ea[0] && !rq_we[0]) chk("rnd_core_rdata", core_rdata, exp_rd[0]);
      if (ea[1] && !rq_we[1]) chk("rnd_dma_rdata", dma_rdata, exp_rd[1]);
      for (int p = 0; p < 2; p++) el[p] = pend[p] && !ea[p];
      if ((c >= free_c) && (el[0] || el[1])) begin
        if (el[0] && el[1]) begin
`ifdef DMEM_ARB_RR_EN
          w = last ? 0 : 1;
`else
          w = 0;
`endif
        end else begin
          w = el[0] ? 0 : 1;
        end
        free_c = c + 3;
        due[w] = c + 3;
        gcyc   = c;
        exp_ma = rq_addr[w][9:2];
        exp_we = rq_we[w];
        exp_wd = rq_wd[w];
        if (rq_we[w]) ref_mem[exp_ma] = rq_wd[w];
        else          exp_rd[w] = ref_mem[exp_ma];
        last = w[0];
      end
      for (int p = 0; p < 2; p++) if (ea[p]) pend[p] = 0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
